isqrt_seq: RTL

Parametrised sequential integer square-root unit. It computes the root with a restoring digit-by-digit algorithm, resolving one root bit per cycle, and returns both root and remainder.
- Adds selectable round-to-nearest, an exact-square flag, a start/busy/done handshake and a synchronous abort.
- Sits between the switch/bidir input capture logic and the seven-segment digit mux. It replaces the linear-search square-root datapath.

---
 rtl/isqrt_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential restoring square root, one root bit per cycle,
// with optional round-to-nearest, exact-square flag and start/busy/done handshake.
`default_nettype none

module isqrt_seq #(
  parameter int IN_W = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    clr,
  input  logic                    round_mode,
  input  logic [IN_W-1:0]         radicand,
  output logic                    busy,
  output logic                    done,
  output logic [(IN_W+1)/2:0]     root,
  output logic [(IN_W+1)/2:0]     rem,
  output logic                    exact
);

  localparam int N   = (IN_W + 1) / 2;
  localparam int OPW = 2 * N;
  localparam int RW  = N + 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [OPW-1:0]  r_op;
  logic [N-1:0]    r_q;
  logic [N:0]      r_r;
  logic [CW-1:0]   r_i;
  logic            r_mode;

  logic [N+2:0]    w_rsh;
  logic [N+3:0]    w_trial;
  logic            w_neg;
  logic [N-1:0]    w_q_nxt;
  logic [N:0]      w_r_nxt;
  logic [RW-1:0]   w_root_fin;

  // One restoring step. The partial remainder never exceeds 2*q, so the
  // shifted remainder fits in N+2 bits; one extra bit carries the borrow.
  always_comb begin
    w_rsh   = {r_r, r_op[OPW-1 -: 2]};
    w_trial = {1'b0, w_rsh} - {2'b00, r_q, 2'b01};
    w_neg   = w_trial[N+3];
    w_q_nxt = r_q << 1;
    w_q_nxt[0] = ~w_neg;
    if (w_neg) begin
      w_r_nxt = w_rsh[N:0];
    end else begin
      w_r_nxt = w_trial[N:0];
    end
  end

  // Nearest-integer rounding: round up exactly when rem > floor root.
  always_comb begin
    w_root_fin = {1'b0, r_q};
    if (r_mode && (r_r > {1'b0, r_q})) begin
      w_root_fin = {1'b0, r_q} + RW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_RUN;
      S_RUN:    if (r_i == '0) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (clr) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_i    <= '0;
      r_mode <= 1'b0;
      root   <= '0;
      rem    <= '0;
      exact  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!clr) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_op   <= OPW'(radicand);
              r_mode <= round_mode;
              r_q    <= '0;
              r_r    <= '0;
              r_i    <= C_LAST;
            end
          end
          S_RUN: begin
            r_op <= r_op << 2;
            r_q  <= w_q_nxt;
            r_r  <= w_r_nxt;
            if (r_i != '0) begin
              r_i <= r_i - CW'(1);
            end
          end
          S_FINISH: begin
            root  <= w_root_fin;
            rem   <= r_r;
            exact <= (r_r == '0);
            done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
